// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer and its combinational MAC datapath.
package mac_pkg;

  // Default operand, accumulator and lane-count sizes.
  localparam int MAC_A_WIDTH   = 8;
  localparam int MAC_B_WIDTH   = 8;
  localparam int MAC_SUM_WIDTH = 22;
  localparam int MAC_LANES     = 5;

  // Width of the lane select, the lane index and the length field.
  localparam int SEL_WIDTH = 3;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/mac_unit_fx_mux_input_8.sv
// Combinational multi-lane MAC: sum = A[select] * B + C, truncated to the sum width.
module mac_unit_fx_mux_input_8
  import mac_pkg::*;
#(
  parameter int A_width   = MAC_A_WIDTH,
  parameter int B_width   = MAC_B_WIDTH,
  parameter int SUM_width = MAC_SUM_WIDTH,
  parameter int LANES     = MAC_LANES
) (
  input  logic [A_width*LANES-1:0] A,
  input  logic [B_width-1:0]       B,
  input  logic [SUM_width-1:0]     C,
  input  logic                     TC,
  input  logic [SEL_WIDTH-1:0]     select,
  output logic [SUM_width-1:0]     sum
);

  logic [A_width-1:0]   lane;
  logic [SUM_width-1:0] a_ext;
  logic [SUM_width-1:0] b_ext;

  // Pick the selected lane; selects beyond the last lane read as zero.
  always_comb begin
    lane = '0;
    for (int k = 0; k < LANES; k++) begin
      if (select == SEL_WIDTH'(k)) begin
        lane = A[k*A_width +: A_width];
      end
    end
  end

  // Extend both operands to the sum width so the truncated product is correct modulo 2^SUM_width.
  always_comb begin
    if (TC) begin
      a_ext = {{(SUM_width-A_width){lane[A_width-1]}}, lane};
      b_ext = {{(SUM_width-B_width){B[B_width-1]}}, B};
    end else begin
      a_ext = {{(SUM_width-A_width){1'b0}}, lane};
      b_ext = {{(SUM_width-B_width){1'b0}}, B};
    end
  end

  assign sum = a_ext * b_ext + C;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer that steps the shared MAC through lanes 0..len-1 and returns the sum on valid/ready.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int A_width   = MAC_A_WIDTH,
  parameter int B_width   = MAC_B_WIDTH,
  parameter int SUM_width = MAC_SUM_WIDTH,
  parameter int LANES     = MAC_LANES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [SEL_WIDTH-1:0]     len,
  input  logic [A_width*LANES-1:0] inst_A,
  input  logic [B_width-1:0]       inst_B,
  input  logic [SUM_width-1:0]     inst_C,
  input  logic                     inst_TC,
  output logic                     busy,
  output logic [SEL_WIDTH-1:0]     mac_select,
  output logic [A_width*LANES-1:0] mac_A,
  output logic [B_width-1:0]       mac_B,
  output logic [SUM_width-1:0]     mac_C,
  output logic                     mac_TC,
  input  logic [SUM_width-1:0]     mac_sum,
  output logic [SUM_width-1:0]     SUM_out,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam logic [SEL_WIDTH-1:0] MAX_LEN = SEL_WIDTH'(LANES);

  state_t               state;
  logic [SUM_width-1:0] acc;
  logic [SEL_WIDTH-1:0] idx;
  logic [SEL_WIDTH-1:0] cnt;

  // The MAC sees the lane index and running accumulator straight from their registers.
  assign mac_select = idx;
  assign mac_C      = acc;

  // Command FSM: latch on accept, walk the lanes feeding each partial sum back, then hold the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      SUM_out   <= '0;
      mac_A     <= '0;
      mac_B     <= '0;
      mac_TC    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mac_A  <= inst_A;
            mac_B  <= inst_B;
            mac_TC <= inst_TC;
            acc    <= inst_C;
            idx    <= '0;
            busy   <= 1'b1;
            if (len == '0) begin
              cnt       <= '0;
              SUM_out   <= inst_C;
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              cnt   <= (len > MAX_LEN) ? MAX_LEN : len;
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc <= mac_sum;
          if (idx == cnt - SEL_WIDTH'(1)) begin
            idx       <= '0;
            SUM_out   <= mac_sum;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            idx <= idx + SEL_WIDTH'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl wired to the combinational MAC datapath.
module tb_mac_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  len;
  logic [39:0] inst_A;
  logic [7:0]  inst_B;
  logic [21:0] inst_C;
  logic        inst_TC;
  logic        busy;
  logic [2:0]  mac_select;
  logic [39:0] mac_A;
  logic [7:0]  mac_B;
  logic [21:0] mac_C;
  logic        mac_TC;
  logic [21:0] mac_sum;
  logic [21:0] SUM_out;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  mac_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .inst_A     (inst_A),
    .inst_B     (inst_B),
    .inst_C     (inst_C),
    .inst_TC    (inst_TC),
    .busy       (busy),
    .mac_select (mac_select),
    .mac_A      (mac_A),
    .mac_B      (mac_B),
    .mac_C      (mac_C),
    .mac_TC     (mac_TC),
    .mac_sum    (mac_sum),
    .SUM_out    (SUM_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  mac_unit_fx_mux_input_8 mac (
    .A      (mac_A),
    .B      (mac_B),
    .C      (mac_C),
    .TC     (mac_TC),
    .select (mac_select),
    .sum    (mac_sum)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges despite the bounded loops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Dot product of the first n lanes plus C, with plain integer arithmetic, truncated to 22 bits.
  function automatic logic [21:0] refDot(input logic [39:0] a, input logic [7:0] b,
                                         input logic [21:0] c, input logic tc, input int n);
    longint total;
    longint av;
    longint bv;
    logic [7:0] lane;
    int lanes;
    lanes = (n > 5) ? 5 : n;
    total = longint'(c);
    if (tc) bv = longint'($signed(b));
    else    bv = longint'(b);
    for (int k = 0; k < lanes; k++) begin
      lane = a[k*8 +: 8];
      if (tc) av = longint'($signed(lane));
      else    av = longint'(lane);
      total = total + av * bv;
    end
    return total[21:0];
  endfunction

  // Count one comparison and report it if the observed value differs from the expected one.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Scramble the command inputs so the DUT must be relying on its latched copies.
  task automatic scrambleInputs(input logic noise);
    if (noise) begin
      start   = 1'($urandom);
      len     = 3'($urandom);
      inst_A  = {8'($urandom), 32'($urandom)};
      inst_B  = 8'($urandom);
      inst_C  = 22'($urandom);
      inst_TC = 1'($urandom);
    end else begin
      start = 1'b0;
    end
  endtask

  // Run one command end to end: accept, lane walk, backpressured hold, handshake.
  task automatic applyStimulus(input logic [2:0] l, input logic [39:0] a, input logic [7:0] b,
                               input logic [21:0] c, input logic tc, input int delay,
                               input logic noise);
    logic [21:0] expSum;
    int n;
    int cyc;
    n = (l > 3'd5) ? 5 : int'(l);
    expSum = refDot(a, b, c, tc, n);
    @(negedge clk);
    start = 1'b1; len = l; inst_A = a; inst_B = b; inst_C = c; inst_TC = tc;
    out_ready = 1'b0;
    @(negedge clk);
    cyc = 1;
    scrambleInputs(noise);
    checkOutput("busy_after_accept", 64'(busy), 64'd1);
    while (!out_valid && cyc <= n + 3) begin
      checkOutput("run_select", 64'(mac_select), 64'(cyc - 1));
      checkOutput("run_acc", 64'(mac_C), 64'(refDot(a, b, c, tc, cyc - 1)));
      @(negedge clk);
      cyc++;
      scrambleInputs(noise);
    end
    checkOutput("valid_cycle", 64'(cyc), 64'(n + 1));
    checkOutput("hold_select", 64'(mac_select), 64'd0);
    checkOutput("sum", 64'(SUM_out), 64'(expSum));
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      scrambleInputs(noise);
      checkOutput("hold_valid", 64'(out_valid), 64'd1);
      checkOutput("hold_sum", 64'(SUM_out), 64'(expSum));
      checkOutput("hold_busy", 64'(busy), 64'd1);
    end
    out_ready = 1'b1;
    start = noise;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    checkOutput("post_valid", 64'(out_valid), 64'd0);
    checkOutput("post_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [39:0] ra;
    rst = 1'b1; start = 1'b0; len = '0; inst_A = '0; inst_B = '0; inst_C = '0;
    inst_TC = 1'b0; out_ready = 1'b0;
    #3;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_sum", 64'(SUM_out), 64'd0);
    checkOutput("reset_select", 64'(mac_select), 64'd0);
    checkOutput("reset_mac_C", 64'(mac_C), 64'd0);
    checkOutput("reset_mac_A", 64'(mac_A), 64'd0);
    checkOutput("reset_mac_B", 64'(mac_B), 64'd0);
    checkOutput("reset_mac_TC", 64'(mac_TC), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed commands");
    applyStimulus(3'd5, 40'h05_04_03_02_01, 8'd2, 22'd10, 1'b0, 0, 1'b0);
    applyStimulus(3'd1, 40'h00_00_00_00_FF, 8'h03, 22'd0, 1'b1, 0, 1'b0);
    applyStimulus(3'd1, 40'h00_00_00_00_01, 8'h01, 22'h3FFFFF, 1'b0, 0, 1'b0);
    applyStimulus(3'd7, 40'h01_01_01_01_01, 8'h01, 22'd0, 1'b0, 1, 1'b0);
    applyStimulus(3'd0, 40'h12_34_56_78_9A, 8'h55, 22'h00ABC, 1'b0, 0, 1'b0);
    applyStimulus(3'd3, 40'h80_7F_80_81_7F, 8'h80, 22'h2AAAAA, 1'b1, 3, 1'b1);
    applyStimulus(3'd2, 40'h00_00_00_09_07, 8'd3, 22'd1, 1'b0, 0, 1'b0);

    $display("[TB] reset during RUN");
    @(negedge clk);
    start = 1'b1; len = 3'd5; inst_A = 40'h05_04_03_02_01; inst_B = 8'd9;
    inst_C = 22'd77; inst_TC = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_run_busy", 64'(busy), 64'd0);
    checkOutput("rst_run_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_run_sum", 64'(SUM_out), 64'd0);
    checkOutput("rst_run_select", 64'(mac_select), 64'd0);
    checkOutput("rst_run_acc", 64'(mac_C), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(3'd4, 40'h00_0A_0B_0C_0D, 8'd5, 22'd100, 1'b0, 1, 1'b0);

    $display("[TB] reset during HOLD");
    @(negedge clk);
    start = 1'b1; len = 3'd0; inst_C = 22'h1234;
    @(negedge clk); start = 1'b0;
    checkOutput("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_hold_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_hold_sum", 64'(SUM_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] random commands");
    for (int i = 0; i < 40; i++) begin
      ra = {8'($urandom), 32'($urandom)};
      applyStimulus(3'($urandom), ra, 8'($urandom), 22'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
